// File: rtl/wb_pkg.sv
// Writeback stage shared types: decoded instruction bundle,
// syscall FSM state encoding and default widths.
package wb_pkg;

   localparam int XLEN_D    = 64;
   localparam int RADDR_W_D = 5;
   localparam int NARGS_D   = 8;

   typedef struct packed {
      logic                 is_load;
      logic                 is_store;
      logic                 is_ecall;
      logic [RADDR_W_D-1:0] rd;
      logic                 en_rd;
   } decoded_inst_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      DRAIN = 3'd4
   } wb_state_e;

endpackage

// File: rtl/wb_syscall_stage_mux.sv
// Writeback result select and register-file write gating.
// x0 is never written.
module wb_result_mux
   import wb_pkg::*;
#(
   parameter int XLEN = XLEN_D
) (
   input  decoded_inst_t   i_inst,
   input  logic [XLEN-1:0] i_alu,
   input  logic [XLEN-1:0] i_mem,
   input  logic [XLEN-1:0] i_rsp,
   input  logic            i_retire,
   output logic            o_we,
   output logic [XLEN-1:0] o_wdata
);

   logic w_is_mem;

   assign w_is_mem = i_inst.is_load | i_inst.is_store;

   // pick the result source for the retiring instruction
   always_comb begin
      o_wdata = i_alu;
      unique case (1'b1)
         w_is_mem:        o_wdata = i_mem;
         i_inst.is_ecall: o_wdata = i_rsp;
         default:         o_wdata = i_alu;
      endcase
   end

   // write only on retire with a real destination
   always_comb begin
      o_we = i_retire & i_inst.en_rd & (i_inst.rd != '0);
   end

endmodule

// File: rtl/wb_syscall_stage.sv
// Writeback stage: result select, retire counter and ECALL
// handshake to an external syscall unit.
module wb_syscall_stage
   import wb_pkg::*;
#(
   parameter int XLEN    = XLEN_D,
   parameter int RADDR_W = RADDR_W_D,
   parameter int NARGS   = NARGS_D
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wb_valid,
   input  logic                  flush,
   input  decoded_inst_t         inst,
   input  logic [XLEN-1:0]       alu_result,
   input  logic [XLEN-1:0]       mem_result,
   input  logic [NARGS*XLEN-1:0] args,
   output logic                  sc_req_valid,
   input  logic                  sc_req_ready,
   output logic [NARGS*XLEN-1:0] sc_req_args,
   input  logic                  sc_rsp_valid,
   input  logic [XLEN-1:0]       sc_rsp_data,
   output logic                  rf_we,
   output logic [RADDR_W-1:0]    rf_waddr,
   output logic [XLEN-1:0]       rf_wdata,
   output logic                  stall,
   output logic [XLEN-1:0]       instret
);

   wb_state_e             r_state;
   logic                  r_req_valid;
   logic [NARGS*XLEN-1:0] r_args;
   logic [XLEN-1:0]       r_rsp_q;
   logic [XLEN-1:0]       r_instret;

   logic w_live;
   logic w_detect;
   logic w_retire;
   logic w_busy;

   // live instruction, ECALL detect and retire qualification
   always_comb begin
      w_live   = wb_valid & ~flush;
      w_detect = (r_state == IDLE) & w_live & inst.is_ecall;
      w_retire = ((r_state == IDLE) & w_live & ~inst.is_ecall)
               | ((r_state == DONE) & ~flush);
      w_busy   = (r_state == REQ) | (r_state == WAIT)
               | (r_state == DRAIN);
   end

   assign stall        = w_detect | w_busy;
   assign sc_req_valid = r_req_valid;
   assign sc_req_args  = r_args;
   assign instret      = r_instret;
   assign rf_waddr     = RADDR_W'(inst.rd);

   wb_result_mux #(
      .XLEN (XLEN)
   ) u_mux (
      .i_inst   (inst),
      .i_alu    (alu_result),
      .i_mem    (mem_result),
      .i_rsp    (r_rsp_q),
      .i_retire (w_retire),
      .o_we     (rf_we),
      .o_wdata  (rf_wdata)
   );

   // syscall FSM, latched request/response and retire counter
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_req_valid <= 1'b0;
         r_args      <= '0;
         r_rsp_q     <= '0;
         r_instret   <= '0;
      end else begin
         r_instret <= r_instret + XLEN'(w_retire);
         unique case (r_state)
            IDLE: begin
               if (w_detect) begin
                  r_args      <= args;
                  r_req_valid <= 1'b1;
                  r_state     <= REQ;
               end
            end
            REQ: begin
               if (sc_req_ready) begin
                  r_req_valid <= 1'b0;
                  r_state     <= flush ? DRAIN : WAIT;
               end else if (flush) begin
                  r_req_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            WAIT: begin
               if (sc_rsp_valid) begin
                  if (!flush) begin
                     r_rsp_q <= sc_rsp_data;
                  end
                  r_state <= flush ? IDLE : DONE;
               end else if (flush) begin
                  r_state <= DRAIN;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            DRAIN: begin
               if (sc_rsp_valid) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_req_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_syscall_stage.sv
// Randomised scoreboard bench for the writeback/syscall stage.
// The bench plays upstream pipeline and syscall unit.
module tb_wb_syscall_stage;
   import wb_pkg::*;

   localparam int XLEN  = 64;
   localparam int NARGS = 8;
   localparam int RW    = 5;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  wb_valid = 1'b0;
   logic                  flush = 1'b0;
   decoded_inst_t         inst = '0;
   logic [XLEN-1:0]       alu_result = '0;
   logic [XLEN-1:0]       mem_result = '0;
   logic [NARGS*XLEN-1:0] args = '0;
   logic                  sc_req_ready = 1'b0;
   logic                  sc_rsp_valid = 1'b0;
   logic [XLEN-1:0]       sc_rsp_data = '0;
   logic                  sc_req_valid;
   logic [NARGS*XLEN-1:0] sc_req_args;
   logic                  rf_we;
   logic [RW-1:0]         rf_waddr;
   logic [XLEN-1:0]       rf_wdata;
   logic                  stall;
   logic [XLEN-1:0]       instret;

   wb_syscall_stage #(
      .XLEN    (XLEN),
      .RADDR_W (RW),
      .NARGS   (NARGS)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wb_valid     (wb_valid),
      .flush        (flush),
      .inst         (inst),
      .alu_result   (alu_result),
      .mem_result   (mem_result),
      .args         (args),
      .sc_req_valid (sc_req_valid),
      .sc_req_ready (sc_req_ready),
      .sc_req_args  (sc_req_args),
      .sc_rsp_valid (sc_rsp_valid),
      .sc_rsp_data  (sc_rsp_data),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .stall        (stall),
      .instret      (instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [RW-1:0]   rd;
      logic [XLEN-1:0] data;
   } wr_t;

   wr_t wq[$];
   wr_t e;

   int errors = 0;
   int checks = 0;
   int hs_cnt = 0;
   int hs_exp = 0;

   logic                  mon_on = 1'b0;
   logic                  exp_stall = 1'b0;
   logic                  exp_reqv = 1'b0;
   logic                  chk_args = 1'b0;
   logic                  inc_pend = 1'b0;
   logic [XLEN-1:0]       m_instret = '0;
   logic [NARGS*XLEN-1:0] exp_args = '0;
   logic [NARGS*XLEN-1:0] a;

   task automatic check(string nm, logic [XLEN-1:0] act,
                        logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // monitor: compares DUT outputs mid-cycle against the model
   initial begin
      forever begin
         @(negedge clk);
         if (mon_on) begin
            check("stall", 64'(stall), 64'(exp_stall));
            check("req_valid", 64'(sc_req_valid), 64'(exp_reqv));
            check("instret", instret, m_instret);
            if (chk_args) begin
               for (int i = 0; i < NARGS; i++) begin
                  check($sformatf("req_args_lane%0d", i),
                        sc_req_args[i*XLEN +: XLEN],
                        exp_args[i*XLEN +: XLEN]);
               end
            end
            if (rf_we) begin
               if (wq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_write: got rd=%0d data=%h expected none",
                           rf_waddr, rf_wdata);
               end else begin
                  e = wq.pop_front();
                  check("waddr", 64'(rf_waddr), 64'(e.rd));
                  check("wdata", rf_wdata, e.data);
               end
            end
            if (sc_req_valid && sc_req_ready) hs_cnt++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (inc_pend) begin
         m_instret = m_instret + 1;
         inc_pend  = 1'b0;
      end
      sc_req_ready = 1'b0;
      sc_rsp_valid = 1'b0;
   endtask

   task automatic bubble(logic f);
      step();
      wb_valid  = 1'b0;
      flush     = f;
      inst      = '0;
      exp_stall = 1'b0;
      exp_reqv  = 1'b0;
      chk_args  = 1'b0;
   endtask

   // kind: 0 alu, 1 load, 2 store
   task automatic retire(int kind, logic [RW-1:0] rd, logic en,
                         logic f, logic [XLEN-1:0] av,
                         logic [XLEN-1:0] mv);
      decoded_inst_t ri;
      ri          = '0;
      ri.is_load  = (kind == 1);
      ri.is_store = (kind == 2);
      ri.rd       = rd;
      ri.en_rd    = en;
      step();
      wb_valid   = 1'b1;
      flush      = f;
      inst       = ri;
      alu_result = av;
      mem_result = mv;
      exp_stall  = 1'b0;
      exp_reqv   = 1'b0;
      chk_args   = 1'b0;
      if (!f) begin
         inc_pend = 1'b1;
         if (en && rd != 0)
            wq.push_back('{rd, (kind == 0) ? av : mv});
      end
   endtask

   // mode: 0 none, 1 flush on detect, 2 flush in REQ,
   // 3 flush on handshake, 4 flush in WAIT, 5 flush with
   // response, 6 flush in DONE
   task automatic ecall(logic [RW-1:0] rd, logic en,
                        logic [NARGS*XLEN-1:0] av, int nlow,
                        int nwait, int mode, logic [XLEN-1:0] rsp);
      decoded_inst_t ei;
      logic killed;
      ei          = '0;
      ei.is_ecall = 1'b1;
      ei.rd       = rd;
      ei.en_rd    = en;
      killed      = 1'b0;
      step();
      wb_valid  = 1'b1;
      inst      = ei;
      args      = av;
      flush     = (mode == 1);
      exp_stall = (mode != 1);
      exp_reqv  = 1'b0;
      chk_args  = 1'b0;
      if (mode == 1) return;
      for (int k = 0; k < nlow; k++) begin
         step();
         flush     = (mode == 2 && k == nlow - 1);
         exp_stall = 1'b1;
         exp_reqv  = 1'b1;
         chk_args  = 1'b1;
         exp_args  = av;
      end
      if (mode == 2) begin
         step();
         wb_valid  = 1'b0;
         inst      = '0;
         flush     = 1'b0;
         exp_stall = 1'b0;
         exp_reqv  = 1'b0;
         return;
      end
      step();
      sc_req_ready = 1'b1;
      flush        = (mode == 3);
      exp_stall    = 1'b1;
      exp_reqv     = 1'b1;
      chk_args     = 1'b1;
      exp_args     = av;
      hs_exp++;
      killed = (mode == 3);
      for (int k = 0; k < nwait; k++) begin
         step();
         if (killed) begin
            wb_valid = 1'b0;
            inst     = '0;
         end
         flush     = (mode == 4 && k == 0);
         exp_stall = 1'b1;
         exp_reqv  = 1'b0;
         chk_args  = 1'b0;
         if (flush) killed = 1'b1;
      end
      step();
      if (killed) begin
         wb_valid = 1'b0;
         inst     = '0;
      end
      sc_rsp_valid = 1'b1;
      sc_rsp_data  = rsp;
      flush        = (mode == 5);
      exp_stall    = 1'b1;
      exp_reqv     = 1'b0;
      chk_args     = 1'b0;
      if (flush) killed = 1'b1;
      step();
      exp_stall = 1'b0;
      exp_reqv  = 1'b0;
      if (killed) begin
         wb_valid = 1'b0;
         inst     = '0;
         flush    = 1'b0;
      end else begin
         flush = (mode == 6);
         if (mode != 6) begin
            inc_pend = 1'b1;
            if (en && rd != 0) wq.push_back('{rd, rsp});
         end
      end
   endtask

   function automatic logic [NARGS*XLEN-1:0] rnd_args();
      logic [NARGS*XLEN-1:0] r;
      for (int i = 0; i < NARGS; i++)
         r[i*XLEN +: XLEN] = {$urandom, $urandom};
      return r;
   endfunction

   initial begin
      int kind, mode, nlow, nwait;
      reset_n   = 1'b0;
      exp_args  = '0;
      chk_args  = 1'b1;
      step();
      mon_on = 1'b1;
      step();
      reset_n = 1'b1;

      retire(0, 5'd5, 1'b1, 1'b0, 64'h1234, 64'h0);
      retire(1, 5'd0, 1'b1, 1'b0, 64'h0, 64'hDEAD_BEEF);
      retire(2, 5'd9, 1'b1, 1'b0, 64'h1, 64'hCAFE);

      a = rnd_args();
      a[7*XLEN +: XLEN] = 64'd93;
      a[0 +: XLEN]      = 64'd7;
      ecall(5'd10, 1'b1, a, 3, 2, 0, 64'h2A);
      ecall(5'd11, 1'b1, rnd_args(), 2, 1, 2, 64'h77);
      ecall(5'd12, 1'b1, rnd_args(), 1, 2, 4, 64'h55);
      ecall(5'd13, 1'b1, rnd_args(), 0, 1, 3, 64'h66);
      ecall(5'd14, 1'b1, rnd_args(), 1, 1, 5, 64'h67);
      ecall(5'd15, 1'b1, rnd_args(), 0, 0, 6, 64'h68);
      ecall(5'd16, 1'b1, rnd_args(), 0, 0, 1, 64'h69);
      ecall(5'd0, 1'b1, rnd_args(), 0, 0, 0, 64'h6A);

      a = rnd_args();
      step();
      wb_valid  = 1'b1;
      inst      = '{is_load: 1'b0, is_store: 1'b0, is_ecall: 1'b1,
                    rd: 5'd17, en_rd: 1'b1};
      args      = a;
      flush     = 1'b0;
      exp_stall = 1'b1;
      exp_reqv  = 1'b0;
      chk_args  = 1'b0;
      step();
      sc_req_ready = 1'b1;
      exp_reqv     = 1'b1;
      chk_args     = 1'b1;
      exp_args     = a;
      hs_exp++;
      step();
      exp_reqv = 1'b0;
      chk_args = 1'b0;
      step();
      reset_n  = 1'b0;
      wb_valid = 1'b0;
      inst     = '0;
      step();
      reset_n   = 1'b1;
      m_instret = '0;
      exp_stall = 1'b0;
      exp_reqv  = 1'b0;
      chk_args  = 1'b1;
      exp_args  = '0;
      bubble(1'b0);

      force dut.r_instret = '1;
      #1;
      release dut.r_instret;
      m_instret = '1;
      retire(0, 5'd3, 1'b1, 1'b0, 64'hABC, 64'h0);
      bubble(1'b0);

      for (int n = 0; n < 300; n++) begin
         kind = int'($urandom_range(0, 9));
         if (kind == 0) begin
            bubble(($urandom_range(0, 3) == 0));
         end else if (kind <= 5) begin
            retire(int'($urandom_range(0, 2)),
                   RW'($urandom_range(0, 31)),
                   ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 9) == 0),
                   {$urandom, $urandom}, {$urandom, $urandom});
         end else begin
            mode  = int'($urandom_range(0, 6));
            nlow  = int'($urandom_range((mode == 2) ? 1 : 0, 3));
            nwait = int'($urandom_range((mode == 4) ? 1 : 0, 3));
            ecall(RW'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) != 0), rnd_args(),
                  nlow, nwait, mode, {$urandom, $urandom});
         end
      end

      bubble(1'b0);
      bubble(1'b0);
      bubble(1'b0);
      @(posedge clk);
      #1;
      mon_on = 1'b0;
      check("write_queue_empty", 64'(wq.size()), 64'd0);
      check("handshakes", 64'(hs_cnt), 64'(hs_exp));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
